// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: 8N1 UART receiver feeding an inferred-RAM byte FIFO.
//
// Ports:
//   clk        system clock, everything on its rising edge
//   reset      asynchronous, active-low; clears all state
//   serial_rx  asynchronous UART line (idle high)
//   data       FIFO head byte, meaningful while data_valid=1 (0 otherwise)
//   data_valid FIFO non-empty and data holds the head byte
//   data_ack   pop strobe, only honoured while data_valid=1
//   level      bytes currently stored, 0..2^ADDR_WIDTH
//   overrun    sticky: a received byte was dropped because the FIFO was full
//   frame_err  sticky: a stop bit was sampled low
//   err_clear  one-cycle pulse clearing both sticky flags
module uart_rx_buffer #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_rx,
    output logic [7:0]            data,
    output logic                  data_valid,
    input  logic                  data_ack,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overrun,
    output logic                  frame_err,
    input  logic                  err_clear
);
    localparam int BIT_CYCLES  = CLK_FREQ / BAUD;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES + 1);
    localparam int DEPTH       = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q, shift_d;
    logic                  rx_meta_q, rx_s_q, rx_prev_q;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  dv_q, dv_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;

    logic                  expire, fall, push, stop_err;
    logic                  pop, full, wr_en, drop, rd_en;

    logic [7:0]            mem [DEPTH];
    logic [7:0]            rd_data;

    // Counter is loaded with N and expires on the cycle it reads 1, so the
    // sample lands exactly N cycles after the load decision.
    assign expire = (cnt_q == CNT_W'(1));
    assign fall   = rx_prev_q & ~rx_s_q;

    // RX state machine
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        stop_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    cnt_d   = CNT_W'(HALF_CYCLES);
                    state_d = S_START;
                end
            end
            S_START: begin
                if (expire) begin
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                        cnt_d     = CNT_W'(BIT_CYCLES);
                    end else begin
                        state_d = S_IDLE;   // glitch, not a real start bit
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (expire) begin
                    shift_d = {rx_s_q, shift_q[7:1]};   // LSB arrives first
                    cnt_d   = CNT_W'(BIT_CYCLES);
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (expire) begin
                    // Back to IDLE at mid-stop-bit: a held-low line shows no
                    // new falling edge until it has gone high again.
                    state_d  = S_IDLE;
                    push     = rx_s_q;
                    stop_err = ~rx_s_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO control. A read is only issued while data_valid=0 and the FIFO is
    // non-empty and not being written into the same slot, so the RAM never
    // sees a read and write to one address in the same cycle.
    assign pop   = dv_q & data_ack;
    assign full  = (level_q == (ADDR_WIDTH+1)'(DEPTH));
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;
    assign rd_en = ~dv_q & (level_q != '0);

    always_comb begin
        wptr_d  = wr_en ? wptr_q + ADDR_WIDTH'(1) : wptr_q;
        rptr_d  = pop   ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
        level_d = level_q;
        if (wr_en && !pop)      level_d = level_q + (ADDR_WIDTH+1)'(1);
        else if (!wr_en && pop) level_d = level_q - (ADDR_WIDTH+1)'(1);
        // Pop leaves a one-cycle bubble while the next head is read out.
        dv_d        = dv_q ? ~data_ack : rd_en;
        overrun_d   = (overrun_q & ~err_clear) | drop;
        frame_err_d = (frame_err_q & ~err_clear) | stop_err;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            dv_q        <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_meta_q   <= serial_rx;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            dv_q        <= dv_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Plain synchronous RAM, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q] <= shift_q;
        if (rd_en) rd_data <= mem[rptr_q];
    end

    // Gate with valid so data reads 0 out of reset without resetting the RAM.
    assign data       = dv_q ? rd_data : 8'h00;
    assign data_valid = dv_q;
    assign level      = level_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: stimulus pushes expected bytes into a queue, a
// monitor process pops and compares each byte the DUT offers.
module tb_uart_rx_buffer;
    localparam int CLK_FREQ = 12000000;
    localparam int BAUD     = 115200;
    localparam int AW       = 4;
    localparam int DEPTH    = 1 << AW;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int HALF     = BIT / 2;
    // Cycle offsets from the cycle the line is driven low: E = c+2.
    localparam int T_OFF    = 2 + HALF + 9 * BIT;

    logic          clk = 1'b0, reset = 1'b0, serial_rx = 1'b1;
    logic          data_ack = 1'b0, err_clear = 1'b0;
    logic [7:0]    data;
    logic          data_valid, overrun, frame_err;
    logic [AW:0]   level;

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_buffer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .serial_rx(serial_rx), .data(data),
        .data_valid(data_valid), .data_ack(data_ack), .level(level),
        .overrun(overrun), .frame_err(frame_err), .err_clear(err_clear));

    int         chk_cnt = 0, pass_cnt = 0;
    logic [7:0] exp_q[$];
    bit         drain_en = 0;
    int         pop_at = -1;
    bit         exp_ovr = 0, exp_fe = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        chk_cnt++;
        if (act == exp_v) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endtask

    // Monitor: consume whatever the DUT offers while draining is enabled.
    initial forever begin
        @(negedge clk);
        data_ack = 1'b0;
        if (reset && data_valid && (drain_en || cyc == pop_at)) begin
            if (exp_q.size() == 0) chk("unexpected_byte", int'(data), -1);
            else chk("byte", int'(data), int'(exp_q.pop_front()));
            data_ack = 1'b1;
        end
    end

    task automatic align();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Reference model: a good stop bit queues the byte unless the FIFO is
    // full (and nothing pops at that moment), which sets overrun instead.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit co_pop);
        if (stop_ok) begin
            if (exp_q.size() < DEPTH || co_pop) exp_q.push_back(b);
            else exp_ovr = 1;
        end else begin
            exp_fe = 1;
        end
        serial_rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            serial_rx = b[i];
            idle(BIT);
        end
        serial_rx = stop_ok;
        idle(BIT);
        serial_rx = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic pulse_clear();
        align();
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
        @(negedge clk);
        exp_fe  = 0;
        exp_ovr = 0;
    endtask

    initial begin
        int c;
        logic [7:0] r;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", int'(data), 0);
        chk("rst_valid", int'(data_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        reset = 1'b1;
        align();

        // Single byte: exact latency, then a pop with its bubble
        c = cyc;
        fork
            send_frame(8'hA5, 1, 0);
            begin
                wait_until(c + T_OFF + 1);
                chk("t1_valid", int'(data_valid), 0);
                chk("t1_level", int'(level), 1);
                @(negedge clk);
                chk("t2_valid", int'(data_valid), 1);
                chk("t2_data", int'(data), 8'hA5);
            end
        join
        drain_en = 1;
        wait_drain(200);
        @(negedge clk);
        chk("pop_valid", int'(data_valid), 0);
        chk("pop_level", int'(level), 0);
        chk("pop_frame_err", int'(frame_err), 0);
        chk("pop_overrun", int'(overrun), 0);

        // Back-to-back frames, no idle gap
        drain_en = 0;
        align();
        send_frame(8'h00, 1, 0);
        send_frame(8'hFF, 1, 0);
        send_frame(8'h55, 1, 0);
        @(negedge clk);
        chk("b2b_level", int'(level), 3);
        chk("b2b_flags", int'({overrun, frame_err}), 0);
        drain_en = 1;
        wait_drain(200);

        // Short low glitch is rejected
        align();
        serial_rx = 1'b0;
        idle(20);
        serial_rx = 1'b1;
        idle(300);
        @(negedge clk);
        chk("glitch_level", int'(level), 0);
        chk("glitch_valid", int'(data_valid), 0);
        align();
        send_frame(8'h3C, 1, 0);
        wait_drain(200);

        // Framing error and clear
        align();
        c = cyc;
        fork
            send_frame(8'h81, 0, 0);
            begin
                wait_until(c + T_OFF);
                chk("fe_at_T", int'(frame_err), 0);
                @(negedge clk);
                chk("fe_at_T1", int'(frame_err), int'(exp_fe));
            end
        join
        @(negedge clk);
        chk("fe_level", int'(level), 0);
        pulse_clear();
        chk("fe_cleared", int'(frame_err), 0);
        align();
        send_frame(8'($urandom_range(0, 255)), 1, 0);
        wait_drain(200);

        // Random bytes with random gaps, drained on the fly
        align();
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 30));
            send_frame(8'($urandom_range(0, 255)), 1, 0);
        end
        wait_drain(200);
        @(negedge clk);
        chk("rand_overrun", int'(overrun), int'(exp_ovr));
        chk("rand_frame_err", int'(frame_err), int'(exp_fe));

        // Fill to capacity, one extra byte is dropped
        drain_en = 0;
        align();
        for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1, 0);
        @(negedge clk);
        chk("full_level", int'(level), DEPTH);
        chk("full_overrun", int'(overrun), int'(exp_ovr));
        chk("full_valid", int'(data_valid), 1);
        pulse_clear();
        chk("ovr_cleared", int'(overrun), 0);

        // Push coincident with a pop while full
        align();
        c = cyc;
        pop_at = c + T_OFF;
        r = 8'($urandom_range(0, 255));
        fork
            send_frame(r, 1, 1);
            begin
                wait_until(c + T_OFF + 1);
                chk("pushpop_level", int'(level), DEPTH);
                chk("pushpop_overrun", int'(overrun), 0);
            end
        join
        pop_at = -1;
        drain_en = 1;
        wait_drain(500);

        // Reset during data bit 4
        drain_en = 0;
        align();
        send_frame(8'($urandom_range(0, 255)), 1, 0);
        send_frame(8'h81, 0, 0);
        @(negedge clk);
        chk("pre_rst_level", int'(level), 1);
        chk("pre_rst_fe", int'(frame_err), 1);
        align();
        r = 8'($urandom_range(0, 255));
        serial_rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 4; i++) begin
            serial_rx = r[i];
            idle(BIT);
        end
        serial_rx = r[4];
        idle(HALF);
        reset = 1'b0;
        #1;
        chk("mid_rst_data", int'(data), 0);
        chk("mid_rst_valid", int'(data_valid), 0);
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_overrun", int'(overrun), 0);
        chk("mid_rst_frame_err", int'(frame_err), 0);
        exp_q.delete();
        exp_fe = 0;
        exp_ovr = 0;
        serial_rx = 1'b1;
        idle(5);
        reset = 1'b1;
        align();
        drain_en = 1;
        send_frame(8'h7E, 1, 0);
        wait_drain(200);
        @(negedge clk);
        chk("end_level", int'(level), 0);
        chk("end_flags", int'({overrun, frame_err}), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
